// File: rtl/adc_sequencer.sv
// Sample-rate scheduler and channel sequencer for the SPI ADC interface.
// Issues one conversion per channel on every sample tick and buffers each result in a valid/ready register.
module adc_sequencer #(
  parameter int unsigned SAMPLE_DIV = 1134,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CH_WIDTH   = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                clr_err,
  output logic                conv_start,
  output logic [CH_WIDTH-1:0] conv_ch,
  input  logic                conv_busy,
  input  logic                conv_done,
  input  logic [15:0]         conv_value,
  output logic                smp_valid,
  output logic [15:0]         smp_data,
  output logic [CH_WIDTH-1:0] smp_ch,
  input  logic                smp_ready,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CH_WIDTH-1:0] CH_LAST  = CH_WIDTH'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    NEXT
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               tick;
  logic               can_load;

  assign tick     = EN && (div_cnt == DIV_LAST);
  assign can_load = !smp_valid || smp_ready;

  // Decoded from state and busy so the pulse lands one cycle after the tick
  // and only in a cycle where the engine is observed idle.
  assign conv_start = (state == START) && !conv_busy;

  always_ff @(posedge CLK) begin
    if (RST || !EN || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      conv_ch     <= '0;
      to_cnt      <= '0;
      smp_valid   <= 1'b0;
      smp_data    <= '0;
      smp_ch      <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Clears come first so any set event later in this block wins.
      if (clr_err) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end

      if (smp_valid && smp_ready) begin
        smp_valid <= 1'b0;
      end

      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            conv_ch <= '0;
            state   <= START;
          end
        end

        START: begin
          if (!conv_busy) begin
            to_cnt <= '0;
            state  <= WAIT;
          end
        end

        WAIT: begin
          if (conv_done) begin
            if (can_load) begin
              smp_valid <= 1'b1;
              smp_data  <= conv_value;
              smp_ch    <= conv_ch;
            end else begin
              overrun <= 1'b1;
            end
            state <= NEXT;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= NEXT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        NEXT: begin
          if (conv_ch == CH_LAST) begin
            state <= IDLE;
          end else begin
            conv_ch <= conv_ch + 1'b1;
            state   <= START;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
